// File: rtl/ex_fu_sched.sv
// EX-stage scheduler: tracks ALU / pipelined MULT / LOAD work and round-robins one completion bus (CDB).
// Latency: ALU issue->CDB 1 cycle, MULT MULT_LAT+1 cycles minimum, LOAD 1 cycle after the load response.
// Backpressure: issue_ready drops while the target unit is busy; a held MULT buffer freezes the whole pipe.
// Ports: clock/reset, flush; issue_valid/fu/tag/rob_idx -> issue_ready; alu_result_in; mult_advance and
//        mult_result_in; ld_req_valid/ld_req_grant/ld_resp_valid/ld_resp_data; cdb_valid/tag/rob_idx/data.
module ex_fu_sched #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 6,
    parameter int ROB_W    = 5,
    parameter int MULT_LAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [1:0]       issue_fu,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [ROB_W-1:0] issue_rob_idx,
    output logic             issue_ready,
    input  logic [XLEN-1:0]  alu_result_in,
    output logic             mult_advance,
    input  logic [XLEN-1:0]  mult_result_in,
    output logic             ld_req_valid,
    input  logic             ld_req_grant,
    input  logic             ld_resp_valid,
    input  logic [XLEN-1:0]  ld_resp_data,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [ROB_W-1:0] cdb_rob_idx,
    output logic [XLEN-1:0]  cdb_data
);
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
    } ctx_t;

    typedef struct packed {
        ctx_t            ctx;
        logic [XLEN-1:0] dat;
    } res_t;

    typedef enum logic [2:0] {LD_IDLE, LD_REQ, LD_WAIT, LD_DONE, LD_DRAIN} ld_state_t;

    ld_state_t           ld_state, ld_state_nxt;
    logic                alu_vld, mult_vld;
    res_t                alu_buf, mult_buf, ld_buf, cdb_res;
    logic [MULT_LAT-1:0] pipe_vld;
    ctx_t                pipe_ctx [MULT_LAT];
    logic [1:0]          rr_ptr, rr_ptr_nxt;
    logic [2:0]          src_vld, grant;
    logic                acc_alu, acc_mult, acc_ld;
    ctx_t                issue_ctx;

    assign issue_ctx = '{tag: issue_tag, rob: issue_rob_idx};

    // Source index: 0 = ALU, 1 = MULT, 2 = LOAD. The load buffer is full exactly in DONE.
    assign src_vld = {ld_state == LD_DONE, mult_vld, alu_vld};

    // Round-robin: scan from rr_ptr, first valid source wins, pointer moves past the winner.
    always_comb begin : cdb_arb
        int   idx;
        logic found;
        grant      = '0;
        rr_ptr_nxt = rr_ptr;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < 3; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= 3) idx = idx - 3;
            if (!flush && !found && src_vld[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                rr_ptr_nxt = (idx == 2) ? 2'd0 : 2'(idx + 1);
            end
        end
    end

    always_comb begin
        cdb_res = alu_buf;
        if (grant[1])      cdb_res = mult_buf;
        else if (grant[2]) cdb_res = ld_buf;
    end

    assign cdb_valid   = |grant;
    assign cdb_tag     = cdb_res.ctx.tag;
    assign cdb_rob_idx = cdb_res.ctx.rob;
    assign cdb_data    = cdb_res.dat;

    // The pipe only moves when its last stage has somewhere to land.
    assign mult_advance = !mult_vld || grant[1];
    assign ld_req_valid = (ld_state == LD_REQ);

    always_comb begin
        issue_ready = 1'b0;
        unique case (issue_fu)
            2'd0:    issue_ready = !alu_vld || grant[0];
            2'd1:    issue_ready = mult_advance;
            2'd2:    issue_ready = (ld_state == LD_IDLE);
            default: issue_ready = 1'b0;
        endcase
    end

    assign acc_alu  = issue_valid && issue_ready && !flush && (issue_fu == 2'd0);
    assign acc_mult = issue_valid && issue_ready && !flush && (issue_fu == 2'd1);
    assign acc_ld   = issue_valid && issue_ready && !flush && (issue_fu == 2'd2);

    // Load FSM. A flush with a response still owed parks in DRAIN so that stale
    // response can never complete a later load.
    always_comb begin
        ld_state_nxt = ld_state;
        unique case (ld_state)
            LD_IDLE:  if (acc_ld) ld_state_nxt = LD_REQ;
            LD_REQ: begin
                if (flush)             ld_state_nxt = ld_req_grant ? LD_DRAIN : LD_IDLE;
                else if (ld_req_grant) ld_state_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                if (flush)              ld_state_nxt = ld_resp_valid ? LD_IDLE : LD_DRAIN;
                else if (ld_resp_valid) ld_state_nxt = LD_DONE;
            end
            LD_DONE:  if (flush || grant[2]) ld_state_nxt = LD_IDLE;
            LD_DRAIN: if (ld_resp_valid)     ld_state_nxt = LD_IDLE;
            default:  ld_state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_state <= LD_IDLE;
            rr_ptr   <= 2'd0;
            alu_vld  <= 1'b0;
            mult_vld <= 1'b0;
            pipe_vld <= '0;
        end else begin
            ld_state <= ld_state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            if (flush) begin
                alu_vld  <= 1'b0;
                mult_vld <= 1'b0;
                pipe_vld <= '0;
            end else begin
                alu_vld <= acc_alu || (alu_vld && !grant[0]);
                if (mult_advance) begin
                    mult_vld <= pipe_vld[MULT_LAT-1];
                    for (int i = MULT_LAT - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
                    pipe_vld[0] <= acc_mult;
                end
            end
        end
    end

    // Payload registers carry no reset: they are only observed behind their valids.
    always_ff @(posedge clock) begin
        if (acc_alu) alu_buf <= '{ctx: issue_ctx, dat: alu_result_in};
        if (mult_advance) begin
            mult_buf <= '{ctx: pipe_ctx[MULT_LAT-1], dat: mult_result_in};
            for (int i = MULT_LAT - 1; i > 0; i--) pipe_ctx[i] <= pipe_ctx[i-1];
            pipe_ctx[0] <= issue_ctx;
        end
        if (acc_ld) ld_buf.ctx <= issue_ctx;
        if (ld_state == LD_WAIT && ld_resp_valid) ld_buf.dat <= ld_resp_data;
    end

endmodule
